// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART: FSM state encoding and the
// oversampling/frame constants used by both serial engines.
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int DBIT       = 8;
endpackage

// File: rtl/uart_core_if.sv
// Processor-side byte interface plus the serial pins and baud divisor of uart_core.
interface uart_core_if #(parameter int DBIT = 8);
  logic            rd_uart;
  logic            wr_uart;
  logic            rx;
  logic [DBIT-1:0] w_data;
  logic [10:0]     dvsr;
  logic            tx_full;
  logic            rx_empty;
  logic            tx;
  logic [DBIT-1:0] r_data;

  modport master (
    output rd_uart, wr_uart, rx, w_data, dvsr,
    input  tx_full, rx_empty, tx, r_data
  );

  modport slave (
    input  rd_uart, wr_uart, rx, w_data, dvsr,
    output tx_full, rx_empty, tx, r_data
  );
endinterface

// File: rtl/baud_gen.sv
// Free-running divider producing a 1-cycle oversampling tick every dvsr+1 clocks.
module baud_gen (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] i_dvsr,
  output logic        o_tick
);
  logic [10:0] r_cnt;
  logic [10:0] r_dvsr;

  // Divisor is captured only at wrap so a change never truncates a period.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_dvsr <= i_dvsr;
    end else if (r_cnt == r_dvsr) begin
      r_cnt  <= '0;
      r_dvsr <= i_dvsr;
    end else begin
      r_cnt <= r_cnt + 11'd1;
    end
  end

  assign o_tick = (r_cnt == r_dvsr);
endmodule

// File: rtl/fifo.sv
// Circular-buffer FIFO with registered full/empty flags and fall-through read data.
module fifo #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_rd,
  input  logic          i_wr,
  input  logic [DW-1:0] i_wdata,
  output logic          o_empty,
  output logic          o_full,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [2**AW];
  logic [AW-1:0] r_wptr, r_rptr;
  logic          r_full, r_empty;
  logic [AW-1:0] w_wptr_nx, w_rptr_nx, w_wsucc, w_rsucc;
  logic          w_full_nx, w_empty_nx, w_we;

  assign w_wsucc = r_wptr + AW'(1);
  assign w_rsucc = r_rptr + AW'(1);

  always_comb begin
    w_wptr_nx  = r_wptr;
    w_rptr_nx  = r_rptr;
    w_full_nx  = r_full;
    w_empty_nx = r_empty;
    w_we       = 1'b0;
    unique case ({i_wr, i_rd})
      2'b01: begin
        if (!r_empty) begin
          w_rptr_nx  = w_rsucc;
          w_full_nx  = 1'b0;
          w_empty_nx = (w_rsucc == r_wptr);
        end
      end
      2'b10: begin
        if (!r_full) begin
          w_we       = 1'b1;
          w_wptr_nx  = w_wsucc;
          w_empty_nx = 1'b0;
          w_full_nx  = (w_wsucc == r_rptr);
        end
      end
      2'b11: begin
        // When full the pop frees the head slot that the push then reuses.
        w_we      = 1'b1;
        w_wptr_nx = w_wsucc;
        if (r_empty) begin
          w_empty_nx = 1'b0;
          w_full_nx  = (w_wsucc == r_rptr);
        end else begin
          w_rptr_nx = w_rsucc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_wptr  <= w_wptr_nx;
      r_rptr  <= w_rptr_nx;
      r_full  <= w_full_nx;
      r_empty <= w_empty_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_wptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;
endmodule

// File: rtl/uart_rx.sv
// 8N1 receiver: synchronises rx, centres on the start bit, samples mid-bit.
module uart_rx import uart_pkg::*; #(
  parameter int DBIT    = uart_pkg::DBIT,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_rx,
  input  logic            i_s_tick,
  output logic            o_rx_done_tick,
  output logic [DBIT-1:0] o_dout
);
  localparam logic [5:0] MID_LAST  = 6'(OVERSAMPLE / 2 - 1);
  localparam logic [5:0] BIT_LAST  = 6'(OVERSAMPLE - 1);
  localparam logic [5:0] STOP_LAST = 6'(SB_TICK - 1);
  localparam logic [3:0] NB_LAST   = 4'(DBIT - 1);

  logic            r_sync1, r_sync2;
  uart_state_e     r_state, w_state_nx;
  logic [5:0]      r_s, w_s_nx;
  logic [3:0]      r_n, w_n_nx;
  logic [DBIT-1:0] r_b, w_b_nx;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_state <= IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
      r_state <= w_state_nx;
      r_s     <= w_s_nx;
      r_n     <= w_n_nx;
      r_b     <= w_b_nx;
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_s_nx         = r_s;
    w_n_nx         = r_n;
    w_b_nx         = r_b;
    o_rx_done_tick = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!r_sync2) begin
          w_state_nx = START;
          w_s_nx     = '0;
        end
      end
      START: begin
        if (i_s_tick) begin
          if (r_s == MID_LAST) begin
            w_state_nx = DATA;
            w_s_nx     = '0;
            w_n_nx     = '0;
          end else begin
            w_s_nx = r_s + 6'd1;
          end
        end
      end
      DATA: begin
        if (i_s_tick) begin
          if (r_s == BIT_LAST) begin
            w_s_nx = '0;
            w_b_nx = {r_sync2, r_b[DBIT-1:1]};
            if (r_n == NB_LAST) w_state_nx = STOP;
            else                w_n_nx     = r_n + 4'd1;
          end else begin
            w_s_nx = r_s + 6'd1;
          end
        end
      end
      STOP: begin
        if (i_s_tick) begin
          if (r_s == STOP_LAST) begin
            w_state_nx     = IDLE;
            o_rx_done_tick = 1'b1;
          end else begin
            w_s_nx = r_s + 6'd1;
          end
        end
      end
    endcase
  end

  assign o_dout = r_b;
endmodule

// File: rtl/uart_tx.sv
// 8N1 transmitter: serialises the FIFO head LSB first, 16 ticks per bit.
module uart_tx import uart_pkg::*; #(
  parameter int DBIT    = uart_pkg::DBIT,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_tx_start,
  input  logic            i_s_tick,
  input  logic [DBIT-1:0] i_din,
  output logic            o_tx_done_tick,
  output logic            o_tx
);
  localparam logic [5:0] BIT_LAST  = 6'(OVERSAMPLE - 1);
  localparam logic [5:0] STOP_LAST = 6'(SB_TICK - 1);
  localparam logic [3:0] NB_LAST   = 4'(DBIT - 1);

  uart_state_e     r_state, w_state_nx;
  logic [5:0]      r_s, w_s_nx;
  logic [3:0]      r_n, w_n_nx;
  logic [DBIT-1:0] r_b, w_b_nx;
  logic            r_tx, w_tx_nx;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nx;
      r_s     <= w_s_nx;
      r_n     <= w_n_nx;
      r_b     <= w_b_nx;
      r_tx    <= w_tx_nx;
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_s_nx         = r_s;
    w_n_nx         = r_n;
    w_b_nx         = r_b;
    w_tx_nx        = r_tx;
    o_tx_done_tick = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_tx_nx = 1'b1;
        if (i_tx_start) begin
          w_state_nx = START;
          w_s_nx     = '0;
          w_b_nx     = i_din;
        end
      end
      START: begin
        w_tx_nx = 1'b0;
        if (i_s_tick) begin
          if (r_s == BIT_LAST) begin
            w_state_nx = DATA;
            w_s_nx     = '0;
            w_n_nx     = '0;
          end else begin
            w_s_nx = r_s + 6'd1;
          end
        end
      end
      DATA: begin
        w_tx_nx = r_b[0];
        if (i_s_tick) begin
          if (r_s == BIT_LAST) begin
            w_s_nx = '0;
            w_b_nx = {1'b0, r_b[DBIT-1:1]};
            if (r_n == NB_LAST) w_state_nx = STOP;
            else                w_n_nx     = r_n + 4'd1;
          end else begin
            w_s_nx = r_s + 6'd1;
          end
        end
      end
      STOP: begin
        w_tx_nx = 1'b1;
        if (i_s_tick) begin
          if (r_s == STOP_LAST) begin
            w_state_nx     = IDLE;
            o_tx_done_tick = 1'b1;
          end else begin
            w_s_nx = r_s + 6'd1;
          end
        end
      end
    endcase
  end

  assign o_tx = r_tx;
endmodule

// File: rtl/uart_core.sv
// Full-duplex 8N1 UART: baud generator, TX/RX engines and a 4-entry FIFO per direction.
module uart_core import uart_pkg::*; #(
  parameter int DBIT    = uart_pkg::DBIT,
  parameter int SB_TICK = 16,
  parameter int FIFO_AW = 2
) (
  input  logic        clk,
  input  logic        reset,
  uart_core_if.slave  bus
);
  logic            w_tick;
  logic            w_tx_done, w_tx_empty;
  logic [DBIT-1:0] w_tx_head;
  logic            w_rx_done, w_rx_full;
  logic [DBIT-1:0] w_rx_byte;

  baud_gen u_baud (
    .clk    (clk),
    .reset  (reset),
    .i_dvsr (bus.dvsr),
    .o_tick (w_tick)
  );

  fifo #(.DW(DBIT), .AW(FIFO_AW)) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_rd    (w_tx_done),
    .i_wr    (bus.wr_uart),
    .i_wdata (bus.w_data),
    .o_empty (w_tx_empty),
    .o_full  (bus.tx_full),
    .o_rdata (w_tx_head)
  );

  uart_tx #(.DBIT(DBIT), .SB_TICK(SB_TICK)) u_tx (
    .clk            (clk),
    .reset          (reset),
    .i_tx_start     (~w_tx_empty),
    .i_s_tick       (w_tick),
    .i_din          (w_tx_head),
    .o_tx_done_tick (w_tx_done),
    .o_tx           (bus.tx)
  );

  uart_rx #(.DBIT(DBIT), .SB_TICK(SB_TICK)) u_rx (
    .clk            (clk),
    .reset          (reset),
    .i_rx           (bus.rx),
    .i_s_tick       (w_tick),
    .o_rx_done_tick (w_rx_done),
    .o_dout         (w_rx_byte)
  );

  fifo #(.DW(DBIT), .AW(FIFO_AW)) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_rd    (bus.rd_uart),
    .i_wr    (w_rx_done & ~w_rx_full),
    .i_wdata (w_rx_byte),
    .o_empty (bus.rx_empty),
    .o_full  (w_rx_full),
    .o_rdata (bus.r_data)
  );
endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core: table-driven TX/RX frames plus burst, overflow and reset sequences.
module tb_uart_core;
  localparam int DV  = 3;
  localparam int BIT = 16 * (DV + 1);

  typedef struct packed {
    logic [7:0] data;
    logic [9:0] frame;   // line levels in time order, index 0 = start bit
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs [6];

  uart_core_if #(.DBIT(8)) bus ();

  uart_core #(.DBIT(8), .SB_TICK(16), .FIFO_AW(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic [7:0] d);
    bus.w_data  = d;
    bus.wr_uart = 1'b1;
    cyc(1);
    bus.wr_uart = 1'b0;
  endtask

  task automatic pop();
    bus.rd_uart = 1'b1;
    cyc(1);
    bus.rd_uart = 1'b0;
  endtask

  task automatic wait_level(input logic lvl, output int n);
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (bus.tx !== lvl && n < 2 * BIT);
  endtask

  task automatic hold_high(input int n, output bit ok);
    ok = 1'b1;
    repeat (n) begin
      cyc(1);
      if (bus.tx !== 1'b1) ok = 1'b0;
    end
  endtask

  // Independent line decoder: finds the start edge, then samples each bit centre.
  task automatic get_frame(output logic [9:0] f, output int waited);
    f = '0;
    waited = 0;
    while (bus.tx !== 1'b0 && waited < 4 * BIT) begin
      cyc(1);
      waited++;
    end
    if (bus.tx === 1'b0) begin
      cyc(BIT / 2);
      for (int i = 0; i < 10; i++) begin
        f[i] = bus.tx;
        if (i < 9) cyc(BIT);
      end
    end
  endtask

  task automatic send_rx(input logic [9:0] f);
    for (int i = 0; i < 10; i++) begin
      bus.rx = f[i];
      cyc(BIT);
    end
    bus.rx = 1'b1;
  endtask

  initial begin
    logic [9:0] f;
    int         n;
    bit         ok;

    vecs[0] = '{8'h55, 10'b1_01010101_0};
    vecs[1] = '{8'hA3, 10'b1_10100011_0};
    vecs[2] = '{8'h00, 10'b1_00000000_0};
    vecs[3] = '{8'hFF, 10'b1_11111111_0};
    vecs[4] = '{8'h80, 10'b1_10000000_0};
    vecs[5] = '{8'h01, 10'b1_00000001_0};

    bus.rd_uart = 1'b0;
    bus.wr_uart = 1'b0;
    bus.rx      = 1'b1;
    bus.w_data  = '0;
    bus.dvsr    = 11'(DV);
    reset       = 1'b1;
    cyc(3);
    check("reset_tx", bus.tx, 1);
    check("reset_tx_full", bus.tx_full, 0);
    check("reset_rx_empty", bus.rx_empty, 1);
    reset = 1'b0;
    cyc(2);

    // Single byte 0x55: every bit toggles, so each edge-to-edge gap is one bit time.
    wr_byte(8'h55);
    wait_level(1'b0, n);
    check_range("tx_latency", n, 1, DV + 1);
    wait_level(1'b1, n);
    check_range("start_bit_len", n, BIT - (DV + 1), BIT);
    for (int k = 1; k <= 8; k++) begin
      wait_level((k % 2 == 1) ? 1'b0 : 1'b1, n);
      check($sformatf("bit_time_%0d", k - 1), n, BIT);
    end
    hold_high(2 * BIT, ok);
    check("idle_after_55", ok, 1);
    check("tx_full_after_55", bus.tx_full, 0);

    // Divisor boundary: dvsr=0 gives a tick every clock, 16-clock bits.
    bus.dvsr = 11'd0;
    cyc(8);
    wr_byte(8'h55);
    wait_level(1'b0, n);
    wait_level(1'b1, n);
    wait_level(1'b0, n);
    check("bit_time_dvsr0", n, 16);
    cyc(20 * 16);
    bus.dvsr = 11'(DV);
    cyc(8);

    for (int i = 0; i < 6; i++) begin
      wr_byte(vecs[i].data);
      get_frame(f, n);
      check($sformatf("tx_frame_%0h", vecs[i].data), f, vecs[i].frame);
    end
    hold_high(BIT, ok);

    // Burst of five writes two cycles apart; the fifth finds the FIFO full.
    wr_byte(8'hF0); cyc(1);
    wr_byte(8'h0F); cyc(1);
    wr_byte(8'h00);
    check("tx_full_after_3", bus.tx_full, 0);
    cyc(1);
    wr_byte(8'hFF);
    check("tx_full_after_4", bus.tx_full, 1);
    cyc(1);
    wr_byte(8'h00);
    check("tx_full_after_5", bus.tx_full, 1);
    get_frame(f, n);
    check("burst_frame_F0", f, 10'b1_11110000_0);
    get_frame(f, n);
    check("burst_frame_0F", f, 10'b1_00001111_0);
    check_range("burst_gap_2", n, 0, BIT / 2 + 8);
    get_frame(f, n);
    check("burst_frame_00", f, 10'b1_00000000_0);
    check_range("burst_gap_3", n, 0, BIT / 2 + 8);
    get_frame(f, n);
    check("burst_frame_FF", f, 10'b1_11111111_0);
    check_range("burst_gap_4", n, 0, BIT / 2 + 8);
    hold_high(3 * BIT, ok);
    check("burst_fifth_dropped", ok, 1);
    check("tx_full_after_burst", bus.tx_full, 0);

    // Receive three frames, then pop them in order.
    send_rx(10'b1_01010101_0);
    check("rx_empty_after_first", bus.rx_empty, 0);
    send_rx(10'b1_10101010_0);
    send_rx(10'b1_00000000_0);
    cyc(BIT);
    check("rx_head_55", bus.r_data, 8'h55);
    pop();
    check("rx_head_AA", bus.r_data, 8'hAA);
    pop();
    check("rx_head_00", bus.r_data, 8'h00);
    check("rx_not_empty_last", bus.rx_empty, 0);
    pop();
    check("rx_empty_after_3_pops", bus.rx_empty, 1);
    pop();
    check("rx_empty_after_4th_pop", bus.rx_empty, 1);
    send_rx(10'b1_01011010_0);
    check("rx_after_extra_pop", bus.r_data, 8'h5A);
    pop();
    check("rx_empty_after_5A", bus.rx_empty, 1);

    for (int i = 0; i < 6; i++) begin
      send_rx(vecs[i].frame);
      check($sformatf("rx_avail_%0h", vecs[i].data), bus.rx_empty, 0);
      check($sformatf("rx_data_%0h", vecs[i].data), bus.r_data, {24'h0, vecs[i].data});
      pop();
      check($sformatf("rx_drained_%0h", vecs[i].data), bus.rx_empty, 1);
    end

    // RX overflow: five frames, only the first four are kept.
    send_rx(10'b1_00010001_0);
    send_rx(10'b1_00100010_0);
    send_rx(10'b1_00110011_0);
    send_rx(10'b1_01000100_0);
    send_rx(10'b1_01010101_0);
    cyc(BIT);
    check("rxov_0", bus.r_data, 8'h11); pop();
    check("rxov_1", bus.r_data, 8'h22); pop();
    check("rxov_2", bus.r_data, 8'h33); pop();
    check("rxov_3", bus.r_data, 8'h44); pop();
    check("rxov_empty", bus.rx_empty, 1);

    // Reset in the middle of a transmit with both FIFOs holding data.
    send_rx(10'b1_01100110_0);
    check("pre_reset_rx_data", bus.rx_empty, 0);
    wr_byte(8'hC3);
    wr_byte(8'h81);
    wait_level(1'b0, n);
    cyc(3 * BIT);
    reset = 1'b1;
    cyc(1);
    check("reset_mid_tx", bus.tx, 1);
    check("reset_mid_rx_empty", bus.rx_empty, 1);
    check("reset_mid_tx_full", bus.tx_full, 0);
    reset = 1'b0;
    hold_high(3 * BIT, ok);
    check("reset_tx_fifo_cleared", ok, 1);
    wr_byte(8'h3C);
    get_frame(f, n);
    check("post_reset_frame_3C", f, 10'b1_00111100_0);

    cyc(BIT);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
